// File: rtl/inta_sequencer.sv
// inta_sequencer: CPU-side initiator of the 8259-style interrupt acknowledge.
// Synchronises INT, issues two active-low INTA pulses, captures the vector
// from D at the end of the second pulse and hands it to the core over a
// valid/ready handshake, then waits out a recovery period before re-sampling INT.
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - synchronous active-low reset
//   INT          - asynchronous interrupt request from the PIC (active high)
//   int_enable   - gates only the start of a new acknowledge sequence
//   INTA         - interrupt acknowledge to the PIC (active low, registered)
//   D            - PIC data bus, sampled at the end of the second INTA pulse
//   vector       - captured interrupt vector
//   vector_valid - vector/spurious valid to the core
//   vector_ready - core accepts the vector
//   spurious     - INT had gone away by the start of the second pulse
//   busy         - high in every state except IDLE
module inta_sequencer #(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned GAP_W   = 2,
    parameter int unsigned HOLDOFF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT,
    input  logic       int_enable,
    output logic       INTA,
    input  logic [7:0] D,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ready,
    output logic       spurious,
    output logic       busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_GAP  = 3'd2,
        S_P2   = 3'd3,
        S_DLV  = 3'd4,
        S_HOLD = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, int_s_q;
    logic             inta_q, inta_d;
    logic [7:0]       vector_q, vector_d;
    logic             valid_q, valid_d;
    logic             spur_q, spur_d;
    logic             sflag_q, sflag_d;
    logic             busy_q, busy_d;

    // State, timing counter, synchroniser and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sync1_q  <= 1'b0;
            int_s_q  <= 1'b0;
            inta_q   <= 1'b1;
            vector_q <= 8'h00;
            valid_q  <= 1'b0;
            spur_q   <= 1'b0;
            sflag_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync1_q  <= INT;
            int_s_q  <= sync1_q;
            inta_q   <= inta_d;
            vector_q <= vector_d;
            valid_q  <= valid_d;
            spur_q   <= spur_d;
            sflag_q  <= sflag_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inta_d   = inta_q;
        vector_d = vector_q;
        valid_d  = valid_q;
        spur_d   = spur_q;
        sflag_d  = sflag_q;

        unique case (state_q)
            S_IDLE: begin
                inta_d = 1'b1;
                if (int_s_q && int_enable) begin
                    state_d = S_P1;
                    inta_d  = 1'b0;
                    cnt_d   = PULSE_LD;
                end
            end
            S_P1: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    inta_d  = 1'b1;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_P2;
                    inta_d  = 1'b0;
                    cnt_d   = PULSE_LD;
                    sflag_d = ~int_s_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_P2: begin
                // Vector is captured on the same edge INTA is released
                if (cnt_q == '0) begin
                    state_d  = S_DLV;
                    inta_d   = 1'b1;
                    vector_d = D;
                    spur_d   = sflag_q;
                    valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DLV: begin
                inta_d = 1'b1;
                if (vector_ready) begin
                    state_d = S_HOLD;
                    valid_d = 1'b0;
                    cnt_d   = HOLD_LD;
                end
            end
            S_HOLD: begin
                // Expiry edge doubles as the IDLE evaluation so a pending
                // request restarts without an extra idle cycle
                inta_d = 1'b1;
                if (cnt_q == '0) begin
                    if (int_s_q && int_enable) begin
                        state_d = S_P1;
                        inta_d  = 1'b0;
                        cnt_d   = PULSE_LD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                inta_d  = 1'b1;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign INTA         = inta_q;
    assign vector       = vector_q;
    assign vector_valid = valid_q;
    assign spurious     = spur_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: directed and randomized checks of inta_sequencer.
// Expected INTA waveforms, capture timing, spurious qualification and
// recovery gaps are computed from the protocol timing with plain arithmetic.
module tb_inta_sequencer;

    localparam int P = 4;
    localparam int G = 2;
    localparam int H = 4;
    localparam int N = 2 * P + G;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       int_req;
    logic       int_en;
    logic       inta;
    logic [7:0] d_bus;
    logic [7:0] vector;
    logic       vector_valid;
    logic       vready;
    logic       spurious;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inta_sequencer #(.PULSE_W(P), .GAP_W(G), .HOLDOFF(H)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .INT          (int_req),
        .int_enable   (int_en),
        .INTA         (inta),
        .D            (d_bus),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ready (vready),
        .spurious     (spurious),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One acknowledge sequence as seen by a PIC. Expects INT already asserted
    // (or INTA already low). drop_k: cycle after the first INTA fall at which
    // INT is withdrawn (-1 = never during the pulses). keep_int: leave INT high
    // afterwards, expecting an immediate follow-on sequence.
    task automatic do_seq(input logic [7:0] dv, input int rd, input int drop_k,
                          input bit keep_int, input string tag);
        int         n;
        int         since;
        logic [N:0] act;
        logic [N:0] exp;
        bit         sp;
        n = 0;
        while (inta !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_start"}, 32'(n < 40), 32'd1);
        if (n >= 40) return;
        vready = 1'b1;
        for (int t = 0; t <= N; t++) begin
            if (t > 0) tick();
            act[t] = inta;
            exp[t] = (t < P || (t >= P + G && t < N)) ? 1'b0 : 1'b1;
            if (t == drop_k) int_req = 1'b0;
            d_bus = (t >= P + G && t < N) ? dv : ~dv;
        end
        chk({tag, "_pulses"}, 32'(act), 32'(exp));
        // INT withdrawn at cycle k reaches int_s after k+2 edges; it must be
        // visible before the GAP->P2 edge at P+G
        sp = (drop_k >= 0) && (drop_k + 3 <= P + G);
        chk({tag, "_valid_rise"}, 32'(vector_valid), 32'd1);
        chk({tag, "_vector"}, 32'(vector), 32'(dv));
        chk({tag, "_spurious"}, 32'(spurious), 32'(sp));
        if (!keep_int) int_req = 1'b0;
        vready = (rd == 0);
        since = 0;
        for (int i = 0; i < rd; i++) begin
            tick();
            since++;
            chk({tag, "_stall"}, 32'({vector_valid, inta, spurious, vector}),
                32'({1'b1, 1'b1, sp, dv}));
            if (i == rd - 1) vready = 1'b1;
        end
        tick();
        since++;
        chk({tag, "_accept"}, 32'({vector_valid, inta, busy}), 32'({1'b0, 1'b1, 1'b1}));
        vready = 1'($urandom_range(0, 1));
        if (keep_int) begin
            n = 0;
            while (inta !== 1'b0 && n < 40) begin
                tick();
                since++;
                n++;
            end
            chk({tag, "_gap"}, 32'(since), 32'(rd + 1 + H));
        end else begin
            for (int i = 1; i <= H; i++) begin
                tick();
                chk({tag, "_hold"}, 32'({inta, busy}), 32'({1'b1, 1'(i < H)}));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit   ok;
        int   n;
        rst_n   = 1'b0;
        int_req = 1'b0;
        int_en  = 1'b0;
        d_bus   = 8'h00;
        vready  = 1'b0;
        tick();
        tick();
        chk("rst_inta", 32'(inta), 32'd1);
        chk("rst_valid", 32'(vector_valid), 32'd0);
        chk("rst_vector", 32'(vector), 32'd0);
        chk("rst_spur", 32'(spurious), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic acknowledge with ready held high throughout
        int_en  = 1'b1;
        int_req = 1'b1;
        do_seq(8'h4A, 0, -1, 1'b0, "basic");
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (inta !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk("basic_idle", 32'(ok), 32'd1);

        // Backpressure with INT still pending: no pulse until after recovery
        int_req = 1'b1;
        do_seq(8'h5C, 10, -1, 1'b1, "bp");
        do_seq(8'h33, 0, -1, 1'b0, "bp2");

        // INT withdrawn during the first pulse
        int_req = 1'b1;
        do_seq(8'h27, 0, int'($urandom_range(0, P - 1)), 1'b0, "spur");

        // Randomized vectors, stall lengths and INT withdrawal points
        for (int k = 0; k < 8; k++) begin
            int_req = 1'b1;
            do_seq(8'($urandom), int'($urandom_range(0, 4)),
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, P + G - 1)) : -1,
                   1'b0, "rand");
        end

        // Enable gating
        int_en  = 1'b0;
        int_req = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (inta !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk("en_gated", 32'(ok), 32'd1);
        int_en = 1'b1;
        tick();
        chk("en_fall", 32'(inta), 32'd0);
        do_seq(8'h9E, 1, -1, 1'b0, "en");

        // Back-to-back with INT held high
        int_req = 1'b1;
        do_seq(8'h40, 0, -1, 1'b1, "b2b0");
        do_seq(8'h41, 0, -1, 1'b0, "b2b1");

        // Reset during the second pulse
        int_req = 1'b1;
        n = 0;
        while (inta !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk("mrst_start", 32'(n < 40), 32'd1);
        for (int i = 0; i < P + G + 1; i++) tick();
        chk("mrst_in_p2", 32'({inta, busy}), 32'({1'b0, 1'b1}));
        rst_n = 1'b0;
        tick();
        chk("mrst_out", 32'({inta, vector_valid, vector, busy, spurious}), 32'd2048);
        tick();
        rst_n = 1'b1;
        do_seq(8'hC3, 0, -1, 1'b0, "mrst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
